// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/load/execute sequencer for the 4-bit-opcode accumulator micro
module instr_sequencer #(
    parameter int WAIT_MAX = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             CLB,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic             imem_ready,
    input  logic [3:0]       Opcode,
    input  logic             Z,
    input  logic             C,
    output logic             imem_req,
    output logic             LoadIR,
    output logic             IncPC,
    output logic             SelPC,
    output logic             LoadPC,
    output logic             LoadReg,
    output logic             LoadAcc,
    output logic [1:0]       SelAcc,
    output logic [3:0]       SelALU,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);
    localparam int WW = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, EXEC, HALT, FAULT} state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d, wait_inc;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State, fetch-wait counter and retired-instruction counter; reset aborts anything in flight
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            state_q <= IDLE;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; the wait counter only runs while FETCH is stalled, and ready beats the limit
    always_comb begin
        state_d  = state_q;
        wait_inc = wait_q + WW'(1);
        wait_d   = '0;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE:    if (step_mode ? step : start) state_d = FETCH;
            FETCH: begin
                if (imem_ready) state_d = LOAD;
                else begin
                    wait_d = wait_inc;
                    if (wait_inc == WW'(WAIT_MAX)) state_d = FAULT;
                end
            end
            LOAD:    state_d = EXEC;
            EXEC: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (Opcode == 4'hF) ? HALT : step_mode ? IDLE : FETCH;
            end
            default: state_d = state_q;
        endcase
    end

    // Moore strobes; EXEC decodes the opcode and flags into datapath controls
    always_comb begin
        imem_req = state_q == FETCH;
        LoadIR   = state_q == LOAD;
        busy     = state_q == FETCH || state_q == LOAD || state_q == EXEC;
        halted   = state_q == HALT;
        fault    = state_q == FAULT;
        IncPC    = 1'b0;
        SelPC    = 1'b0;
        LoadPC   = 1'b0;
        LoadReg  = 1'b0;
        LoadAcc  = 1'b0;
        SelAcc   = 2'b00;
        SelALU   = 4'b0000;
        if (state_q == EXEC) begin
            case (Opcode)
                4'h1: begin SelALU = 4'b1000; LoadAcc = 1'b1; IncPC = 1'b1; end
                4'h2: begin SelALU = 4'b1100; LoadAcc = 1'b1; IncPC = 1'b1; end
                4'h3: begin SelALU = 4'b0100; LoadAcc = 1'b1; IncPC = 1'b1; end
                4'hB: begin SelALU = 4'b0001; LoadAcc = 1'b1; IncPC = 1'b1; end
                4'hC: begin SelALU = 4'b0011; LoadAcc = 1'b1; IncPC = 1'b1; end
                4'h4: begin SelAcc = 2'b01; LoadAcc = 1'b1; IncPC = 1'b1; end
                4'h5: begin LoadReg = 1'b1; IncPC = 1'b1; end
                4'hD: begin SelAcc = 2'b10; LoadAcc = 1'b1; IncPC = 1'b1; end
                4'h6: begin LoadPC = Z; SelPC = Z; IncPC = !Z; end
                4'h7: begin LoadPC = Z; IncPC = !Z; end
                4'h8: begin LoadPC = C; SelPC = C; IncPC = !C; end
                4'hA: begin LoadPC = C; IncPC = !C; end
                4'hF: IncPC = 1'b0;
                default: IncPC = 1'b1;
            endcase
        end
    end

    assign instr_count = cnt_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed-vector bench for instr_sequencer (WAIT_MAX=8, CNT_W=4)
module tb_instr_sequencer;
    logic clk = 1'b0, CLB = 1'b0, start = 1'b0, step_mode = 1'b0, step = 1'b0;
    logic imem_ready = 1'b0, Z = 1'b0, C = 1'b0;
    logic [3:0] Opcode = 4'h0;
    logic imem_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, busy, halted, fault;
    logic [1:0] SelAcc;
    logic [3:0] SelALU;
    logic [3:0] instr_count;
    logic [15:0] obs;
    int vectors = 0, miscompares = 0;

    // {imem_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU, busy, halted, fault}
    localparam logic [15:0] V_IDLE  = 16'b0_0_0_0_0_0_0_00_0000_0_0_0;
    localparam logic [15:0] V_FETCH = 16'b1_0_0_0_0_0_0_00_0000_1_0_0;
    localparam logic [15:0] V_LOAD  = 16'b0_1_0_0_0_0_0_00_0000_1_0_0;
    localparam logic [15:0] V_HALT  = 16'b0_0_0_0_0_0_0_00_0000_0_1_0;
    localparam logic [15:0] V_FAULT = 16'b0_0_0_0_0_0_0_00_0000_0_0_1;
    localparam logic [15:0] V_NOP   = 16'b0_0_1_0_0_0_0_00_0000_1_0_0;
    localparam logic [15:0] V_XHLT  = 16'b0_0_0_0_0_0_0_00_0000_1_0_0;
    localparam logic [15:0] V_ADD   = 16'b0_0_1_0_0_0_1_00_1000_1_0_0;
    localparam logic [15:0] V_SUB   = 16'b0_0_1_0_0_0_1_00_1100_1_0_0;
    localparam logic [15:0] V_JIMM  = 16'b0_0_0_0_1_0_0_00_0000_1_0_0;
    localparam logic [15:0] V_JREG  = 16'b0_0_0_1_1_0_0_00_0000_1_0_0;

    instr_sequencer #(.WAIT_MAX(8), .CNT_W(4)) dut (
        .clk(clk), .CLB(CLB), .start(start), .step_mode(step_mode), .step(step),
        .imem_ready(imem_ready), .Opcode(Opcode), .Z(Z), .C(C),
        .imem_req(imem_req), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
        .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU),
        .busy(busy), .halted(halted), .fault(fault), .instr_count(instr_count)
    );

    assign obs = {imem_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU, busy, halted, fault};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic apply_reset();
        CLB = 1'b0; start = 1'b0; step = 1'b0; step_mode = 1'b0;
        imem_ready = 1'b0; Z = 1'b0; C = 1'b0; Opcode = 4'h0;
        @(negedge clk);
        @(negedge clk);
        CLB = 1'b1;
    endtask

    task automatic test_reset();
        CLB = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs !== V_IDLE || instr_count !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state outs %b cnt %0d want %b cnt 0", obs, instr_count, V_IDLE);
        end
        CLB = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (obs !== V_IDLE) begin
            miscompares++;
            $display("FAIL reset_idle_hold outs %b want %b", obs, V_IDLE);
        end
    endtask

    task automatic test_run();
        logic [15:0] exp [10] = '{V_FETCH, V_LOAD, V_ADD, V_FETCH, V_LOAD, V_SUB,
                                  V_FETCH, V_LOAD, V_XHLT, V_HALT};
        logic [3:0] ops [10] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'hF, 4'hF, 4'hF};
        apply_reset();
        start = 1'b1; imem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("FAIL run[%0d] outs %b want %b", i, obs, exp[i]);
            end
            Opcode = ops[i];
        end
        vectors++;
        if (instr_count !== 4'd3) begin
            miscompares++;
            $display("FAIL run_count got %0d want 3", instr_count);
        end
        start = 1'b1; step = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_mode = i[0];
            @(negedge clk);
            vectors++;
            if (obs !== V_HALT || instr_count !== 4'd3) begin
                miscompares++;
                $display("FAIL halt_sticky[%0d] outs %b cnt %0d want %b cnt 3", i, obs, instr_count, V_HALT);
            end
        end
    endtask

    task automatic test_decode_step();
        logic [21:0] tbl [17] = '{
            {4'h7, 1'b1, 1'b0, V_JIMM},
            {4'h7, 1'b0, 1'b1, V_NOP},
            {4'h6, 1'b1, 1'b0, V_JREG},
            {4'h6, 1'b0, 1'b1, V_NOP},
            {4'h8, 1'b0, 1'b1, V_JREG},
            {4'h8, 1'b1, 1'b0, V_NOP},
            {4'hA, 1'b0, 1'b1, V_JIMM},
            {4'hA, 1'b1, 1'b0, V_NOP},
            {4'h5, 1'b0, 1'b0, 16'b0_0_1_0_0_1_0_00_0000_1_0_0},
            {4'h4, 1'b0, 1'b0, 16'b0_0_1_0_0_0_1_01_0000_1_0_0},
            {4'hD, 1'b0, 1'b0, 16'b0_0_1_0_0_0_1_10_0000_1_0_0},
            {4'h3, 1'b0, 1'b0, 16'b0_0_1_0_0_0_1_00_0100_1_0_0},
            {4'hB, 1'b0, 1'b0, 16'b0_0_1_0_0_0_1_00_0001_1_0_0},
            {4'hC, 1'b1, 1'b1, 16'b0_0_1_0_0_0_1_00_0011_1_0_0},
            {4'h9, 1'b1, 1'b1, V_NOP},
            {4'hE, 1'b0, 1'b0, V_NOP},
            {4'h0, 1'b1, 1'b1, V_NOP}
        };
        apply_reset();
        step_mode = 1'b1; imem_ready = 1'b1;
        for (int j = 0; j < 17; j++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            vectors++;
            if (obs !== V_FETCH) begin
                miscompares++;
                $display("FAIL step_fetch[%0d] outs %b want %b", j, obs, V_FETCH);
            end
            @(negedge clk);
            vectors++;
            if (obs !== V_LOAD) begin
                miscompares++;
                $display("FAIL step_load[%0d] outs %b want %b", j, obs, V_LOAD);
            end
            Opcode = tbl[j][21:18]; Z = tbl[j][17]; C = tbl[j][16];
            @(negedge clk);
            vectors++;
            if (obs !== tbl[j][15:0]) begin
                miscompares++;
                $display("FAIL decode[%0d] op %h outs %b want %b", j, Opcode, obs, tbl[j][15:0]);
            end
            @(negedge clk);
            vectors++;
            if (obs !== V_IDLE || instr_count !== 4'(j + 1)) begin
                miscompares++;
                $display("FAIL step_idle[%0d] outs %b cnt %0d want %b cnt %0d", j, obs, instr_count, V_IDLE, (j + 1) % 16);
            end
        end
        @(negedge clk);
        vectors++;
        if (obs !== V_IDLE || instr_count !== 4'd1) begin
            miscompares++;
            $display("FAIL step_no_extra outs %b cnt %0d want %b cnt 1", obs, instr_count, V_IDLE);
        end
    endtask

    task automatic test_mode_select();
        apply_reset();
        step_mode = 1'b1; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (obs !== V_IDLE) begin
            miscompares++;
            $display("FAIL start_in_step_mode outs %b want %b", obs, V_IDLE);
        end
        step_mode = 1'b0; start = 1'b0; step = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (obs !== V_IDLE) begin
            miscompares++;
            $display("FAIL step_in_run_mode outs %b want %b", obs, V_IDLE);
        end
        start = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== V_FETCH) begin
            miscompares++;
            $display("FAIL start_and_step_run outs %b want %b", obs, V_FETCH);
        end
        start = 1'b0; step = 1'b0;
    endtask

    task automatic test_fault();
        apply_reset();
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            vectors++;
            if (obs !== V_FETCH) begin
                miscompares++;
                $display("FAIL fault_wait[%0d] outs %b want %b", i, obs, V_FETCH);
            end
        end
        @(negedge clk);
        vectors++;
        if (obs !== V_FAULT) begin
            miscompares++;
            $display("FAIL fault_entry outs %b want %b", obs, V_FAULT);
        end
        imem_ready = 1'b1; start = 1'b1; step = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_mode = i[0];
            @(negedge clk);
            vectors++;
            if (obs !== V_FAULT || instr_count !== 4'd0) begin
                miscompares++;
                $display("FAIL fault_sticky[%0d] outs %b cnt %0d want %b cnt 0", i, obs, instr_count, V_FAULT);
            end
        end
        apply_reset();
        start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                start = 1'b0;
                vectors++;
                if (obs !== V_FETCH) begin
                    miscompares++;
                    $display("FAIL late_ready_wait[%0d][%0d] outs %b want %b", k, i, obs, V_FETCH);
                end
                imem_ready = (i == 7);
            end
            @(negedge clk);
            imem_ready = 1'b0;
            vectors++;
            if (obs !== V_LOAD) begin
                miscompares++;
                $display("FAIL late_ready_load[%0d] outs %b want %b", k, obs, V_LOAD);
            end
            Opcode = (k == 0) ? 4'h0 : 4'hF;
            @(negedge clk);
            vectors++;
            if (obs !== ((k == 0) ? V_NOP : V_XHLT)) begin
                miscompares++;
                $display("FAIL late_ready_exec[%0d] outs %b want %b", k, obs, (k == 0) ? V_NOP : V_XHLT);
            end
        end
        @(negedge clk);
        vectors++;
        if (obs !== V_HALT || instr_count !== 4'd2) begin
            miscompares++;
            $display("FAIL late_ready_halt outs %b cnt %0d want %b cnt 2", obs, instr_count, V_HALT);
        end
    endtask

    task automatic test_wrap();
        int incs = 0;
        apply_reset();
        start = 1'b1; imem_ready = 1'b1; Opcode = 4'h0;
        for (int n = 1; n <= 48; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (IncPC) incs++;
            if (n == 47) step_mode = 1'b1;
            if (n == 48) begin
                vectors++;
                if (instr_count !== 4'd15 || obs !== V_NOP) begin
                    miscompares++;
                    $display("FAIL wrap_last_exec outs %b cnt %0d want %b cnt 15", obs, instr_count, V_NOP);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (obs !== V_IDLE || instr_count !== 4'd0 || incs != 16) begin
            miscompares++;
            $display("FAIL wrap outs %b cnt %0d incpc %0d want %b cnt 0 incpc 16", obs, instr_count, incs, V_IDLE);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        step_mode = 1'b1; imem_ready = 1'b1; Opcode = 4'h0;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        imem_ready = 1'b0; step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        vectors++;
        if (obs !== V_FETCH || instr_count !== 4'd1) begin
            miscompares++;
            $display("FAIL pre_reset outs %b cnt %0d want %b cnt 1", obs, instr_count, V_FETCH);
        end
        #2;
        CLB = 1'b0;
        #1;
        vectors++;
        if (obs !== V_IDLE || instr_count !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset outs %b cnt %0d want %b cnt 0", obs, instr_count, V_IDLE);
        end
        @(negedge clk);
        CLB = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== V_IDLE) begin
            miscompares++;
            $display("FAIL post_reset_idle outs %b want %b", obs, V_IDLE);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_decode_step();
        test_mode_select();
        test_fault();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
